// File: rtl/peripheral_bus_if.sv
// MEM-stage load/store bus between the CPU (master) and the peripheral block (slave).
// Reads are answered combinationally; writes commit on the next rising clock edge.
interface peripheral_bus_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/peripheral_bus.sv
// Memory-mapped timer/LED/switch/systick/8N1 UART responder; reads combinational, writes on clk edge.
// No backpressure: the bus never stalls, and UART_TXD writes arriving while a frame is in flight are dropped.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          BAUD_DIV  = 5208
) (
    input  logic                   clk,
    input  logic                   reset,
    peripheral_bus_if.slave        bus,
    output logic                   irqout,
    output logic [7:0]             led,
    input  logic [7:0]             switch,
    output logic                   uart_tx
);
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    localparam logic [2:0] SEL_TH      = 3'd0;
    localparam logic [2:0] SEL_TL      = 3'd1;
    localparam logic [2:0] SEL_TCON    = 3'd2;
    localparam logic [2:0] SEL_LED     = 3'd3;
    localparam logic [2:0] SEL_SWITCH  = 3'd4;
    localparam logic [2:0] SEL_SYSTICK = 3'd5;
    localparam logic [2:0] SEL_TXD     = 3'd6;
    localparam logic [2:0] SEL_UCON    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    logic [31:0]   r_th;
    logic [31:0]   r_tl;
    logic [2:0]    r_tcon;
    logic [7:0]    r_led;
    logic [7:0]    r_sw_meta;
    logic [7:0]    r_sw_sync;
    logic [31:0]   r_systick;
    logic [7:0]    r_txd;
    logic          r_tx_done;
    uart_state_t   r_state;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;

    uart_state_t   w_state_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic          w_frame_end;
    logic          w_tx_line;
    logic          w_baud_last;

    logic          w_hit;
    logic          w_mapped;
    logic [2:0]    w_sel;
    logic          w_wr_th;
    logic          w_wr_tl;
    logic          w_wr_tcon;
    logic          w_wr_led;
    logic          w_wr_txd;
    logic          w_wr_ucon;
    logic          w_txd_accept;
    logic          w_tx_busy;
    logic          w_tl_max;
    logic          w_ovf;
    logic          w_ovf_irq;
    logic          w_unused;

    // Only word-aligned offsets 0x00..0x1C of the 256-byte window are mapped.
    assign w_hit     = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign w_mapped  = w_hit && (bus.addr[7:5] == 3'b000);
    assign w_sel     = bus.addr[4:2];
    assign w_unused  = &{1'b0, bus.addr[1:0]};

    assign w_wr_th   = bus.wr && w_mapped && (w_sel == SEL_TH);
    assign w_wr_tl   = bus.wr && w_mapped && (w_sel == SEL_TL);
    assign w_wr_tcon = bus.wr && w_mapped && (w_sel == SEL_TCON);
    assign w_wr_led  = bus.wr && w_mapped && (w_sel == SEL_LED);
    assign w_wr_txd  = bus.wr && w_mapped && (w_sel == SEL_TXD);
    assign w_wr_ucon = bus.wr && w_mapped && (w_sel == SEL_UCON);

    assign w_tx_busy    = (r_state != ST_IDLE);
    assign w_txd_accept = w_wr_txd && !w_tx_busy;

    assign w_tl_max  = (r_tl == 32'hFFFF_FFFF);
    assign w_ovf     = r_tcon[0] && w_tl_max;
    assign w_ovf_irq = w_ovf && r_tcon[1];

    assign irqout  = r_tcon[1] & r_tcon[2];
    assign led     = r_led;
    assign uart_tx = w_tx_line;

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.rd && w_mapped) begin
            case (w_sel)
                SEL_TH:      bus.rdata = r_th;
                SEL_TL:      bus.rdata = r_tl;
                SEL_TCON:    bus.rdata = {29'h0, r_tcon};
                SEL_LED:     bus.rdata = {24'h0, r_led};
                SEL_SWITCH:  bus.rdata = {24'h0, r_sw_sync};
                SEL_SYSTICK: bus.rdata = r_systick;
                SEL_TXD:     bus.rdata = {24'h0, r_txd};
                SEL_UCON:    bus.rdata = {30'h0, r_tx_done, w_tx_busy};
                default:     bus.rdata = 32'h0;
            endcase
        end
    end

    // A CPU write to TL beats the timer; an overflow in the same cycle as a TCON write still latches status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th      <= 32'h0;
            r_tl      <= 32'h0;
            r_tcon    <= 3'b000;
            r_led     <= 8'h00;
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
            r_systick <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'd1;
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;

            if (w_wr_th)  r_th  <= bus.wdata;
            if (w_wr_led) r_led <= bus.wdata[7:0];

            if (w_wr_tl)       r_tl <= bus.wdata;
            else if (w_ovf)    r_tl <= r_th;
            else if (r_tcon[0]) r_tl <= r_tl + 32'd1;

            if (w_wr_tcon)      r_tcon <= {bus.wdata[2] | w_ovf_irq, bus.wdata[1:0]};
            else if (w_ovf_irq) r_tcon[2] <= 1'b1;
        end
    end

    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_frame_end = 1'b0;
        w_tx_line   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_txd_accept) begin
                    w_state_nxt = ST_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_START: begin
                w_tx_line = 1'b0;
                if (w_baud_last) begin
                    w_state_nxt = ST_DATA;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                w_tx_line = r_txd[r_bit_cnt];
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = ST_STOP;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    w_state_nxt = ST_IDLE;
                    w_baud_nxt  = '0;
                    w_frame_end = 1'b1;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_txd      <= 8'h00;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            if (w_txd_accept) r_txd <= bus.wdata[7:0];
            r_tx_done  <= w_frame_end | (r_tx_done & ~(w_wr_ucon & bus.wdata[1]));
        end
    end
endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus with BAUD_DIV=4: UART frame, timer wrap/irq, switch sync, decode, reset.
module tb_peripheral_bus;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        irqout;
    logic [7:0]  led;
    logic [7:0]  sw;
    logic        uart_tx;
    int          total = 0;
    int          bad = 0;
    logic [31:0] d;
    logic [9:0]  frame;

    peripheral_bus_if bus();

    peripheral_bus #(.BASE_ADDR(BASE), .BAUD_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irqout  (irqout),
        .led     (led),
        .switch  (sw),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] v);
        bus.addr  = a;
        bus.wdata = v;
        bus.wr    = 1'b1;
        tick();
        bus.wr    = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        v        = bus.rdata;
        bus.rd   = 1'b0;
    endtask

    initial begin
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        sw = 8'h00;
        reset = 1'b0;
        #12;
        chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst_irqout", {31'h0, irqout}, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        rd_reg(BASE + 32'h14, d); chk("rst_systick", d, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // UART frame 0xA5, with a dropped write and a same-cycle read of TXD in the middle
        frame = {1'b1, 8'hA5, 1'b0};
        wr_reg(BASE + 32'h18, 32'hA5);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 10) begin
                bus.addr = BASE + 32'h18; bus.wdata = 32'h3C; bus.wr = 1'b1; bus.rd = 1'b1;
                #1;
                chk("txd_rd_busy", bus.rdata, 32'hA5);
            end else begin
                bus.addr = BASE + 32'h1C; bus.rd = 1'b1;
                #1;
                chk("ucon_busy", bus.rdata, 32'h1);
            end
            chk($sformatf("uart_bit_c%0d", cyc), {31'h0, uart_tx}, {31'h0, frame[cyc/4]});
            tick();
            bus.wr = 1'b0; bus.rd = 1'b0;
        end
        chk("uart_idle_line", {31'h0, uart_tx}, 32'h1);
        rd_reg(BASE + 32'h1C, d); chk("ucon_done", d, 32'h2);
        rd_reg(BASE + 32'h18, d); chk("txd_kept", d, 32'hA5);
        wr_reg(BASE + 32'h1C, 32'h2);
        rd_reg(BASE + 32'h1C, d); chk("ucon_cleared", d, 32'h0);

        // Timer wrap and interrupt
        wr_reg(BASE + 32'h00, 32'hFFFF_FFFC);
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFE);
        wr_reg(BASE + 32'h08, 32'h3);
        rd_reg(BASE + 32'h04, d); chk("tl_fe", d, 32'hFFFF_FFFE);
        chk("irq_pre0", {31'h0, irqout}, 32'h0);
        tick();
        rd_reg(BASE + 32'h04, d); chk("tl_ff", d, 32'hFFFF_FFFF);
        chk("irq_pre1", {31'h0, irqout}, 32'h0);
        tick();
        rd_reg(BASE + 32'h04, d); chk("tl_reload", d, 32'hFFFF_FFFC);
        chk("irq_rise", {31'h0, irqout}, 32'h1);
        rd_reg(BASE + 32'h08, d); chk("tcon_status", d, 32'h7);
        tick();
        chk("irq_hold", {31'h0, irqout}, 32'h1);
        wr_reg(BASE + 32'h08, 32'h3);
        chk("irq_cleared", {31'h0, irqout}, 32'h0);
        rd_reg(BASE + 32'h04, d); chk("tl_after_clr", d, 32'hFFFF_FFFE);
        tick();
        rd_reg(BASE + 32'h04, d); chk("tl_ff2", d, 32'hFFFF_FFFF);

        // TCON write on the exact overflow cycle: status still sets
        wr_reg(BASE + 32'h08, 32'h3);
        rd_reg(BASE + 32'h08, d); chk("tcon_set_wins", d, 32'h7);
        chk("irq_set_wins", {31'h0, irqout}, 32'h1);
        wr_reg(BASE + 32'h04, 32'h5);
        rd_reg(BASE + 32'h04, d); chk("tl_write_wins", d, 32'h5);
        tick();
        rd_reg(BASE + 32'h04, d); chk("tl_inc", d, 32'h6);
        wr_reg(BASE + 32'h08, 32'h0);
        chk("irq_off", {31'h0, irqout}, 32'h0);

        // Switch synchroniser and LED with same-cycle read/write
        sw = 8'h5A;
        rd_reg(BASE + 32'h10, d); chk("sw_c1", d, 32'h0);
        tick();
        rd_reg(BASE + 32'h10, d); chk("sw_c2", d, 32'h0);
        tick();
        rd_reg(BASE + 32'h10, d); chk("sw_c3", d, 32'h5A);
        bus.addr = BASE + 32'h0C; bus.wdata = 32'h1FF; bus.wr = 1'b1; bus.rd = 1'b1;
        #1;
        chk("led_rdwr_old", bus.rdata, 32'h0);
        tick();
        bus.wr = 1'b0; bus.rd = 1'b0;
        chk("led_out", {24'h0, led}, 32'hFF);
        rd_reg(BASE + 32'h0C, d); chk("led_rd", d, 32'hFF);

        // Decode misses
        rd_reg(32'h5000_0000, d); chk("miss_base", d, 32'h0);
        rd_reg(BASE + 32'h40, d); chk("miss_off", d, 32'h0);
        wr_reg(32'h5000_000C, 32'h11);
        chk("miss_wr_led", {24'h0, led}, 32'hFF);
        wr_reg(BASE + 32'h4C, 32'h22);
        chk("unmapped_wr_led", {24'h0, led}, 32'hFF);
        rd_reg(BASE + 32'h14, d);
        tick();
        begin
            logic [31:0] d2;
            rd_reg(BASE + 32'h14, d2);
            chk("systick_step", d2 - d, 32'h1);
        end

        // Reset mid-frame
        sw = 8'h00;
        wr_reg(BASE + 32'h18, 32'h55);
        tick();
        chk("frame2_start", {31'h0, uart_tx}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_mid_uart", {31'h0, uart_tx}, 32'h1);
        chk("rst_mid_led", {24'h0, led}, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        rd_reg(BASE + 32'h14, d); chk("post_rst_systick", d, 32'h0);
        rd_reg(BASE + 32'h00, d); chk("post_rst_th", d, 32'h0);
        rd_reg(BASE + 32'h04, d); chk("post_rst_tl", d, 32'h0);
        rd_reg(BASE + 32'h08, d); chk("post_rst_tcon", d, 32'h0);
        rd_reg(BASE + 32'h0C, d); chk("post_rst_led", d, 32'h0);
        tick();
        rd_reg(BASE + 32'h10, d); chk("post_rst_sw", d, 32'h0);
        rd_reg(BASE + 32'h18, d); chk("post_rst_txd", d, 32'h0);
        rd_reg(BASE + 32'h1C, d); chk("post_rst_ucon", d, 32'h0);
        chk("post_rst_uart", {31'h0, uart_tx}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/peripheral_bus.md
Name: peripheral_bus

Overview:
Memory-mapped I/O responder on the data-memory side of the pipelined CPU; it is the target end of the MEM-stage load/store interface (rd/wr/addr/wdata/rdata).
- Contains a reloadable interval timer that drives the CPU interrupt request, an LED output register, a switch input, a free-running systick counter and an 8N1 UART transmitter.
- Reads are answered combinationally in the same cycle, as the MEM stage expects; writes commit on the rising clock edge.

Parameters:
BASE_ADDR, 32'h4000_0000, base of the 256-byte peripheral window
BAUD_DIV, 5208, clk cycles per UART bit (50 MHz / 9600); legal values are >= 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rd  in  1  MEM-stage read strobe
wr  in  1  MEM-stage write strobe
addr  in  32  byte address; addr[1:0] ignored
wdata  in  32  store data
rdata  out  32  load data, combinational
irqout  out  1  timer interrupt request to the CPU
led  out  8  LED register
switch  in  8  board switches, synchronised internally with 2 flops
uart_tx  out  1  serial line, idles high

Behaviour:
- Decode: hit when addr[31:8] == BASE_ADDR[31:8]; offset = addr[7:0]. Writes with no hit, or to an unmapped offset, are ignored. rdata = 0 unless rd is high and the access hits a mapped offset.
- Register map:
  - 0x00 TH: R/W, timer reload value.
  - 0x04 TL: R/W, timer counter.
  - 0x08 TCON: R/W, 3 bits. [0] enable, [1] irq enable, [2] irq status.
  - 0x0C LED: R/W, [7:0].
  - 0x10 SWITCH: RO, synchronised switch value.
  - 0x14 SYSTICK: RO, increments every cycle and wraps at 2^32.
  - 0x18 UART_TXD: W starts a transmit; R returns the last accepted byte.
  - 0x1C UART_CON: [0] tx_busy (RO); [1] tx_done (sticky, write-1-to-clear).
- Reset (reset=0, asynchronous): all registers 0, systick 0, irqout 0, led 0, uart_tx 1, FSM IDLE, switch synchroniser 0.
- Timer, each cycle with TCON[0]=1:
  - if TL == 32'hFFFF_FFFF, TL <= TH, and TCON[2] <= 1 if TCON[1]=1;
  - otherwise TL <= TL + 1.
- irqout = TCON[1] & TCON[2], combinational from the registers.
- Timer simultaneous events:
  - A CPU write to TL in the same cycle as a timer update: the write wins.
  - A CPU write to TCON: bits [1:0] take wdata. Bit 2 takes wdata[2], OR 1 if an overflow sets status in that same cycle (an interrupt is never lost).
- rd and wr in the same cycle: the read returns the pre-write value.
- UART FSM states: IDLE, START, DATA, STOP. Bit counter runs 0..7; baud counter runs 0..BAUD_DIV-1.
- Write to UART_TXD in IDLE:
  - latch wdata[7:0] and go to START on the next edge, so tx_busy=1 from the next cycle;
  - uart_tx = 0 for BAUD_DIV cycles;
  - DATA: LSB first, BAUD_DIV cycles per bit;
  - STOP: uart_tx = 1 for BAUD_DIV cycles, then IDLE.
- Frame length is exactly 10*BAUD_DIV cycles.
- On the last STOP cycle edge: tx_busy falls and tx_done sets.
- Write to UART_TXD while busy: dropped. The TXD register is unchanged and the frame in flight is unaffected.
- tx_done: set by frame completion, cleared by a UART_CON write with wdata[1]=1. Set wins if both occur in the same cycle.
- A new write accepted in the same cycle tx_busy falls is legal and starts the next frame with no idle gap beyond 1 cycle.
- Reset mid-frame: uart_tx returns to 1 immediately and the frame is abandoned.

Test Plan:
1. BAUD_DIV=4. Write 0x18 <= 0xA5 -> uart_tx is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. tx_busy=1 for 40 cycles, then UART_CON reads 0x2.
2. During test 1's frame, write 0x18 <= 0x3C -> waveform unchanged; UART_TXD reads 0xA5. Then write UART_CON <= 0x2 -> UART_CON reads 0x0.
3. TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=0x3 -> TL goes FFFF_FFFF, then FFFF_FFFC. irqout rises the cycle after the wrap and stays high until TCON <= 0x3 is written.
4. Write TCON <= 0x3 on the exact overflow cycle -> TCON[2]=1 and irqout=1 (set wins). Write TL <= 5 while the timer is running -> TL=5 on the next cycle.
5. switch=0x5A -> reads of 0x10 return 0x5A from the 3rd cycle on. Write LED <= 0x1FF -> led=0xFF.
6. rd at 0x5000_0000 or offset 0x40 -> rdata=0. Assert reset mid-UART-frame -> uart_tx=1, systick=0 and all registers read 0 after release.
